// File: rtl/fetch_stage_if.sv
// Fetch-side bus bundle: imem read request/response plus the
// if_id register handed to decode.
interface fetch_stage_if;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_mask;
    logic        mem_req_en;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_valid;
    logic        mem_rsp_done;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        if_id_ready;

    modport master (
        output mem_req_addr,
        output mem_req_mask,
        output mem_req_en,
        input  mem_rsp_data,
        input  mem_rsp_valid,
        input  mem_rsp_done,
        output if_id_inst,
        output if_id_pc,
        output if_id_valid,
        input  if_id_ready
    );

    modport slave (
        input  mem_req_addr,
        input  mem_req_mask,
        input  mem_req_en,
        output mem_rsp_data,
        output mem_rsp_valid,
        output mem_rsp_done,
        input  if_id_inst,
        input  if_id_pc,
        input  if_id_valid,
        output if_id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads imem one word at a
// time and buffers results for decode in a small FIFO.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_en,
    input  logic [31:0]   redirect_pc,
    output logic          fetch_fault,
    fetch_stage_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ISSUE, WAIT, HALT} state_t;

    state_t        state, state_nx;
    logic          run;
    logic          stale, stale_nx;
    logic [31:0]   pc, pc_nx;
    logic [31:0]   req_addr, req_addr_nx;
    logic [31:0]   inst_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          req_en, done, push, pop;
    logic          fault_nx, head_valid;

    assign head_valid = (count != '0);
    assign pop = head_valid && bus.if_id_ready && !redirect_en;

    always_comb begin
        state_nx    = state;
        stale_nx    = stale;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        req_en      = 1'b0;
        done        = 1'b0;
        push        = 1'b0;
        fault_nx    = 1'b0;
        case (state)
            ISSUE: begin
                req_en = run && (count < DEPTH_C);
                if (req_en) req_addr_nx = pc;
            end
            WAIT:    req_en = 1'b1;
            default: ;
        endcase
        done = req_en && bus.mem_rsp_done;
        if (req_en && !done) state_nx = WAIT;
        // A stale response only frees the bus; pc already holds the new target
        if (done) begin
            state_nx = ISSUE;
            if (stale) begin
                stale_nx = 1'b0;
            end else if (bus.mem_rsp_valid) begin
                push  = 1'b1;
                pc_nx = pc + 32'd4;
            end else begin
                fault_nx = 1'b1;
                state_nx = HALT;
            end
        end
        if (redirect_en) begin
            pc_nx    = redirect_pc & ~32'h3;
            push     = 1'b0;
            fault_nx = 1'b0;
            stale_nx = req_en && !done;
            state_nx = (req_en && !done) ? WAIT : ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ISSUE;
            run         <= 1'b0;
            stale       <= 1'b0;
            pc          <= RESET_PC;
            req_addr    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            run         <= 1'b1;
            stale       <= stale_nx;
            pc          <= pc_nx;
            req_addr    <= req_addr_nx;
            fetch_fault <= fault_nx;
            if (redirect_en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    inst_q[wr_ptr] <= bus.mem_rsp_data;
                    pc_q[wr_ptr]   <= pc;
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_req_en   = req_en;
    assign bus.mem_req_mask = 4'b1111;
    assign bus.mem_req_addr = !req_en ? '0 :
                              (state == WAIT) ? req_addr : pc;
    assign bus.if_id_valid  = head_valid;
    assign bus.if_id_inst   = head_valid ? inst_q[rd_ptr] : '0;
    assign bus.if_id_pc     = head_valid ? pc_q[rd_ptr] : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (reset pc 0 and 0xFFFF_FFF8),
// a configurable-latency imem responder and an in-order stream model.
module tb_fetch_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        redir      [2];
    logic [31:0] redir_pc   [2];
    logic        ready      [2];
    int          lat        [2];
    logic [31:0] fault_addr [2];

    logic        req_w   [2];
    logic        done_w  [2];
    logic        valid_w [2];
    logic        fault_w [2];
    logic [31:0] addr_w  [2];
    logic [31:0] inst_w  [2];
    logic [31:0] ipc_w   [2];
    logic [3:0]  mask_w  [2];
    int          dcnt    [2];
    int          fcnt    [2];

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam logic [31:0] RPC = (g == 0) ? 32'h0 : 32'hFFFF_FFF8;
        fetch_stage_if bus ();
        int          wcnt = 0;
        logic [31:0] exp_pc;
        logic [31:0] p_addr;
        logic        p_req = 1'b0;
        logic        p_done = 1'b0;
        logic        p_rst = 1'b1;

        fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(2)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .redirect_en(redir[g]),
            .redirect_pc(redir_pc[g]),
            .fetch_fault(fault_w[g]),
            .bus        (bus)
        );

        assign bus.mem_rsp_done  = bus.mem_req_en && (wcnt >= lat[g]);
        assign bus.mem_rsp_data  = mem_fn(bus.mem_req_addr);
        assign bus.mem_rsp_valid = (bus.mem_req_addr != fault_addr[g]);
        assign bus.if_id_ready   = ready[g];
        assign req_w[g]   = bus.mem_req_en;
        assign done_w[g]  = bus.mem_rsp_done;
        assign addr_w[g]  = bus.mem_req_addr;
        assign mask_w[g]  = bus.mem_req_mask;
        assign valid_w[g] = bus.if_id_valid;
        assign inst_w[g]  = bus.if_id_inst;
        assign ipc_w[g]   = bus.if_id_pc;

        always @(posedge clk)
            wcnt <= (bus.mem_req_en && !bus.mem_rsp_done) ? wcnt + 1 : 0;

        always @(negedge clk) begin
            chk("mask", {28'h0, mask_w[g]}, 32'hF);
            if (!rst_n[g]) begin
                exp_pc  = RPC;
                dcnt[g] = 0;
                fcnt[g] = 0;
                if (!p_rst) begin
                    chk("rst_req_en", {31'h0, req_w[g]}, 32'h0);
                    chk("rst_valid", {31'h0, valid_w[g]}, 32'h0);
                    chk("rst_fault", {31'h0, fault_w[g]}, 32'h0);
                    chk("rst_addr", addr_w[g], 32'h0);
                end
            end else begin
                if (p_req && !p_done) begin
                    if (p_rst) begin
                        chk("hold_en", {31'h0, req_w[g]}, 32'h1);
                        chk("hold_addr", addr_w[g], p_addr);
                    end else begin
                        chk("abandon_en", {31'h0, req_w[g]}, 32'h0);
                    end
                end
                if (req_w[g]) chk("addr_align", {30'h0, addr_w[g][1:0]}, 32'h0);
                if (redir[g]) begin
                    exp_pc = redir_pc[g] & ~32'h3;
                end else if (valid_w[g] && ready[g]) begin
                    chk("pop_pc", ipc_w[g], exp_pc);
                    chk("pop_inst", inst_w[g], mem_fn(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                if (req_w[g] && done_w[g]) dcnt[g]++;
                if (fault_w[g]) fcnt[g]++;
            end
            p_req  = req_w[g];
            p_done = done_w[g];
            p_addr = addr_w[g];
            p_rst  = rst_n[g];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart0(input int l, input logic rdy);
        rst_n[0] = 1'b0;
        redir[0] = 1'b0;
        ready[0] = rdy;
        lat[0]   = l;
        repeat (3) tick();
        rst_n[0] = 1'b1;
    endtask

    task automatic wait_valid(input int g, input int lim);
        for (int n = 0; n < lim && !valid_w[g]; n++) @(negedge clk);
    endtask

    task automatic wait_req(input int g, input int lim);
        for (int n = 0; n < lim && !req_w[g]; n++) @(negedge clk);
    endtask

    initial begin
        logic any_req;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]      = 1'b0;
            redir[i]      = 1'b0;
            redir_pc[i]   = '0;
            ready[i]      = 1'b0;
            lat[i]        = 0;
            fault_addr[i] = 32'h1;
        end
        repeat (3) tick();

        // reset values
        @(negedge clk);
        chk("t0_valid", {31'h0, valid_w[0]}, 32'h0);
        chk("t0_req_en", {31'h0, req_w[0]}, 32'h0);
        chk("t0_inst", inst_w[0], 32'h0);
        chk("t0_pc", ipc_w[0], 32'h0);

        // 0-wait stream
        tick();
        rst_n[0] = 1'b1;
        ready[0] = 1'b1;
        wait_valid(0, 20);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pc", ipc_w[0], 32'(i * 4));
            if (i == 1) chk("t1_inst4", inst_w[0], 32'hFFFB_0004);
            @(negedge clk);
        end

        // FIFO fills, requests stop
        tick();
        restart0(0, 1'b0);
        repeat (8) tick();
        @(negedge clk);
        chk("t2_valid", {31'h0, valid_w[0]}, 32'h1);
        chk("t2_head", ipc_w[0], 32'h0);
        chk("t2_req_off", {31'h0, req_w[0]}, 32'h0);
        chk("t2_fetched", dcnt[0], 32'd2);
        tick();
        ready[0] = 1'b1;
        @(negedge clk);
        wait_req(0, 5);
        chk("t2_resume_addr", addr_w[0], 32'h8);

        // redirect while waiting on 0x10
        tick();
        restart0(3, 1'b1);
        for (int n = 0; n < 100 && !(req_w[0] && addr_w[0] == 32'h10); n++)
            @(negedge clk);
        chk("t3_req10", addr_w[0], 32'h10);
        tick();
        redir[0]    = 1'b1;
        redir_pc[0] = 32'h100;
        tick();
        redir[0] = 1'b0;
        for (int n = 0; n < 10 && !done_w[0]; n++) @(negedge clk);
        chk("t3_done_addr", addr_w[0], 32'h10);
        @(negedge clk);
        chk("t3_new_req", {31'h0, req_w[0]}, 32'h1);
        chk("t3_new_addr", addr_w[0], 32'h100);
        wait_valid(0, 20);
        chk("t3_first_pc", ipc_w[0], 32'h100);

        // redirect flushes a full FIFO
        tick();
        restart0(0, 1'b0);
        repeat (6) tick();
        @(negedge clk);
        chk("t4_full", {31'h0, valid_w[0]}, 32'h1);
        tick();
        redir[0]    = 1'b1;
        redir_pc[0] = 32'h203;
        tick();
        redir[0] = 1'b0;
        @(negedge clk);
        chk("t4_flushed", {31'h0, valid_w[0]}, 32'h0);
        chk("t4_req", {31'h0, req_w[0]}, 32'h1);
        chk("t4_addr", addr_w[0], 32'h200);
        tick();
        ready[0] = 1'b1;
        wait_valid(0, 20);
        chk("t4_first_pc", ipc_w[0], 32'h200);

        // access fault halts fetch
        tick();
        fault_addr[0] = 32'h40;
        restart0(1, 1'b1);
        for (int n = 0; n < 200 && !fault_w[0]; n++) @(negedge clk);
        chk("t5_fault", {31'h0, fault_w[0]}, 32'h1);
        any_req = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            any_req |= req_w[0];
        end
        chk("t5_halted", {31'h0, any_req}, 32'h0);
        chk("t5_pulses", fcnt[0], 32'd1);
        tick();
        redir[0]    = 1'b1;
        redir_pc[0] = 32'h80;
        tick();
        redir[0] = 1'b0;
        @(negedge clk);
        wait_req(0, 5);
        chk("t5_resume_addr", addr_w[0], 32'h80);
        wait_valid(0, 20);
        chk("t5_first_pc", ipc_w[0], 32'h80);
        fault_addr[0] = 32'h1;

        // pc wrap and reset mid-request
        tick();
        ready[1] = 1'b1;
        lat[1]   = 0;
        rst_n[1] = 1'b1;
        wait_valid(1, 20);
        chk("t6_pc0", ipc_w[1], 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t6_pc1", ipc_w[1], 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t6_pc2", ipc_w[1], 32'h0);
        chk("t6_inst2", inst_w[1], 32'hFFFF_0000);
        tick();
        lat[1] = 5;
        @(negedge clk);
        chk("t6_inflight", {31'h0, req_w[1] && !done_w[1]}, 32'h1);
        tick();
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("t6_wait_req", {31'h0, req_w[1]}, 32'h1);
        tick();
        @(negedge clk);
        chk("t6_rst_drop", {31'h0, req_w[1]}, 32'h0);

        tick();
        rst_n[0] = 1'b0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
